// File: rtl/axi4_r_sender_pkg.sv
// Shared constants for the R-channel drop sender: FSM encoding and AXI LEN width.
package axi4_r_sender_pkg;

    // AXI4 ARLEN/AWLEN field width
    localparam int AXI_LEN_W = 8;

    // Depth of the pending-drop queue (power of two)
    localparam int DROP_Q_DEPTH = 4;

    // Sender FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

endpackage

// File: rtl/axi4_r_sender_if.sv
// AXI4 read-data channel bundle; master drives the beat, slave drives rready.
interface axi4_r_sender_if #(
    parameter int ID_WIDTH   = 10,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 4
) ();
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [USER_WIDTH-1:0] ruser;
    logic                  rvalid;
    logic                  rready;

    modport master (output rid, rdata, rresp, rlast, ruser, rvalid, input rready);
    modport slave  (input rid, rdata, rresp, rlast, ruser, rvalid, output rready);
endinterface

// File: rtl/axi_buffer_rab.sv
// Small valid/ready FIFO; head entry is presented combinationally on data_out.
module axi_buffer_rab #(
    parameter int DATA_WIDTH   = 18,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in
);
    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push, pop;

    assign ready_out = (cnt_q != CNT_W'(BUFFER_DEPTH));
    assign valid_out = (cnt_q != '0);
    assign data_out  = mem_q[rd_ptr_q];
    assign push      = valid_in & ready_out;
    assign pop       = valid_out & ready_in;

    // Next-state for pointers, occupancy and storage; push and pop may coincide
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end

    // Control state: asynchronous reset empties the queue
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage: contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/axi4_r_sender.sv
// R-channel sender: forwards downstream read data, and for each queued dropped
// read generates a full-length error burst (zero data, DROP_RESP) towards the
// slave-side master, never splitting a downstream burst already in flight.
module axi4_r_sender
    import axi4_r_sender_pkg::*;
#(
    parameter int         AXI_DATA_WIDTH = 64,
    parameter int         AXI_ID_WIDTH   = 10,
    parameter int         AXI_USER_WIDTH = 4,
    parameter logic [1:0] DROP_RESP      = 2'b10
) (
    input  logic                    axi4_aclk,
    input  logic                    axi4_arstn,
    input  logic [AXI_ID_WIDTH-1:0] trans_id,
    input  logic [AXI_LEN_W-1:0]    trans_len,
    input  logic                    trans_drop,
    output logic                    trans_drop_ready,
    axi4_r_sender_if.master         s_axi4,
    axi4_r_sender_if.slave          m_axi4
);
    logic [0:0]              state_q, state_d;
    logic [AXI_LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                    mid_burst_q, mid_burst_d;
    logic                    q_valid, q_pop, drop_start, s_hs, m_hs;
    logic [AXI_ID_WIDTH-1:0] q_id;
    logic [AXI_LEN_W-1:0]    q_len;

    axi_buffer_rab #(
        .DATA_WIDTH  (AXI_ID_WIDTH + AXI_LEN_W),
        .BUFFER_DEPTH(DROP_Q_DEPTH)
    ) u_drop_q (
        .clk      (axi4_aclk),
        .rstn     (axi4_arstn),
        .data_in  ({trans_id, trans_len}),
        .valid_in (trans_drop),
        .ready_out(trans_drop_ready),
        .data_out ({q_id, q_len}),
        .valid_out(q_valid),
        .ready_in (q_pop)
    );

    // A drop may only start between downstream bursts
    assign drop_start = (state_q == ST_IDLE) & q_valid & ~mid_burst_q;
    assign s_hs       = s_axi4.rvalid & s_axi4.rready;
    assign m_hs       = m_axi4.rvalid & m_axi4.rready;
    assign q_pop      = (state_q == ST_DROP) & s_hs & s_axi4.rlast;

    // R mux: pass-through in IDLE (stalled on the start cycle), generated beats in DROP
    always_comb begin
        s_axi4.rid    = m_axi4.rid;
        s_axi4.rdata  = m_axi4.rdata;
        s_axi4.rresp  = m_axi4.rresp;
        s_axi4.rlast  = m_axi4.rlast;
        s_axi4.ruser  = m_axi4.ruser;
        s_axi4.rvalid = m_axi4.rvalid & ~drop_start;
        m_axi4.rready = s_axi4.rready & ~drop_start;
        if (state_q == ST_DROP) begin
            s_axi4.rid    = q_id;
            s_axi4.rdata  = '0;
            s_axi4.rresp  = DROP_RESP;
            s_axi4.rlast  = (beat_cnt_q == q_len);
            s_axi4.ruser  = '0;
            s_axi4.rvalid = 1'b1;
            m_axi4.rready = 1'b0;
        end
    end

    // Track whether a downstream burst has started but not yet delivered rlast
    always_comb begin
        mid_burst_d = mid_burst_q;
        if (m_hs) mid_burst_d = ~m_axi4.rlast;
    end

    // FSM and beat counter; the counter stops at q_len so 256-beat bursts never wrap
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                beat_cnt_d = '0;
                if (drop_start) state_d = ST_DROP;
            end
            default: begin
                if (s_hs) begin
                    if (s_axi4.rlast) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + AXI_LEN_W'(1);
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            mid_burst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            mid_burst_q <= mid_burst_d;
        end
    end
endmodule

// File: tb/tb_axi4_r_sender.sv
// Directed bench for axi4_r_sender: pass-through, drop bursts, queue limits, reset.
module tb_axi4_r_sender;
    localparam int DW = 64;
    localparam int IW = 10;
    localparam int UW = 4;

    logic          clk = 1'b0;
    logic          arstn;
    logic [IW-1:0] trans_id;
    logic [7:0]    trans_len;
    logic          trans_drop;
    logic          trans_drop_ready;
    int            nvec = 0;
    int            nerr = 0;

    axi4_r_sender_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
    axi4_r_sender_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

    axi4_r_sender #(
        .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW), .DROP_RESP(2'b10)
    ) dut (
        .axi4_aclk       (clk),
        .axi4_arstn      (arstn),
        .trans_id        (trans_id),
        .trans_len       (trans_len),
        .trans_drop      (trans_drop),
        .trans_drop_ready(trans_drop_ready),
        .s_axi4          (s_if),
        .m_axi4          (m_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d,
                         input logic last);
        m_if.rvalid = v;
        m_if.rid    = id;
        m_if.rdata  = d;
        m_if.rlast  = last;
        m_if.rresp  = 2'b00;
        m_if.ruser  = 4'h3;
    endtask

    // Push one drop request; queue must have room
    task automatic push(input logic [IW-1:0] id, input logic [7:0] len);
        trans_id   = id;
        trans_len  = len;
        trans_drop = 1'b1;
        @(negedge clk);
        chk("push_ready", trans_drop_ready, 1'b1);
        tick();
        trans_drop = 1'b0;
    endtask

    // Start cycle in IDLE: nothing forwarded, downstream stalled
    task automatic bubble();
        @(negedge clk);
        chk("bubble_svalid", s_if.rvalid, 1'b0);
        chk("bubble_mready", m_if.rready, 1'b0);
        tick();
    endtask

    // Expect a full generated burst with s_rready held high
    task automatic burst(input logic [IW-1:0] id, input int len);
        for (int b = 0; b <= len; b++) begin
            @(negedge clk);
            chk("burst_valid", s_if.rvalid, 1'b1);
            chk("burst_rid", s_if.rid, id);
            chk("burst_rlast", s_if.rlast, (b == len));
            if (b == 0 || b == len) begin
                chk("burst_rresp", s_if.rresp, 2'b10);
                chk("burst_rdata", s_if.rdata, 64'h0);
                chk("burst_ruser", s_if.ruser, 64'h0);
                chk("burst_mready", m_if.rready, 1'b0);
            end
            tick();
        end
    endtask

    initial begin
        arstn      = 1'b0;
        trans_id   = '0;
        trans_len  = '0;
        trans_drop = 1'b0;
        s_if.rready = 1'b1;
        set_m(1'b1, 10'h12, 64'hDEAD_BEEF, 1'b1);

        // Reset: pass-through, queue empty
        #3;
        chk("rst_svalid", s_if.rvalid, 1'b1);
        chk("rst_rid", s_if.rid, 10'h12);
        chk("rst_rdata", s_if.rdata, 64'hDEAD_BEEF);
        chk("rst_mready", m_if.rready, 1'b1);
        chk("rst_drop_ready", trans_drop_ready, 1'b1);
        s_if.rready = 1'b0;
        #1;
        chk("rst_mready_follow", m_if.rready, 1'b0);
        s_if.rready = 1'b1;
        set_m(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        arstn = 1'b1;
        tick();

        // Drop id=5 len=3
        push(10'h05, 8'd3);
        set_m(1'b1, 10'h66, 64'h1111, 1'b1);
        bubble();
        set_m(1'b0, '0, '0, 1'b0);
        burst(10'h05, 3);
        @(negedge clk);
        chk("after_drop_svalid", s_if.rvalid, 1'b0);
        chk("after_drop_mready", m_if.rready, 1'b1);
        tick();

        // Downstream 4-beat burst, drop pushed mid-burst
        for (int b = 0; b < 4; b++) begin
            set_m(1'b1, 10'h3A, 64'(b + 100), (b == 3));
            if (b == 2) begin
                trans_id = 10'h07; trans_len = 8'd1; trans_drop = 1'b1;
            end
            @(negedge clk);
            chk("mid_svalid", s_if.rvalid, 1'b1);
            chk("mid_rid", s_if.rid, 10'h3A);
            chk("mid_rdata", s_if.rdata, 64'(b + 100));
            chk("mid_rlast", s_if.rlast, (b == 3));
            chk("mid_mready", m_if.rready, 1'b1);
            tick();
            trans_drop = 1'b0;
        end
        set_m(1'b0, '0, '0, 1'b0);
        bubble();
        burst(10'h07, 1);

        // Drop len=0 with s_rready toggling
        push(10'h11, 8'd0);
        s_if.rready = 1'b0;
        bubble();
        for (int i = 0; i < 3; i++) begin
            s_if.rready = (i == 2);
            @(negedge clk);
            chk("hold_valid", s_if.rvalid, 1'b1);
            chk("hold_rid", s_if.rid, 10'h11);
            chk("hold_rlast", s_if.rlast, 1'b1);
            chk("hold_rresp", s_if.rresp, 2'b10);
            tick();
        end
        @(negedge clk);
        chk("len0_done_svalid", s_if.rvalid, 1'b0);
        chk("len0_done_mready", m_if.rready, 1'b1);
        tick();

        // Fill the queue, then one extra push that must be ignored
        s_if.rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            trans_id   = 10'(10'h21 + i);
            trans_len  = (i == 1) ? 8'd1 : (i == 3) ? 8'd2 : 8'd0;
            trans_drop = 1'b1;
            @(negedge clk);
            chk("fill_ready", trans_drop_ready, (i < 4));
            tick();
        end
        trans_drop = 1'b0;
        s_if.rready = 1'b1;
        burst(10'h21, 0);
        bubble();
        burst(10'h22, 1);
        bubble();
        burst(10'h23, 0);
        bubble();
        burst(10'h24, 2);
        @(negedge clk);
        chk("fill_empty_mready", m_if.rready, 1'b1);
        chk("fill_empty_svalid", s_if.rvalid, 1'b0);
        chk("fill_empty_ready", trans_drop_ready, 1'b1);
        tick();

        // Reset during beat 2 of a len=7 drop
        push(10'h30, 8'd7);
        bubble();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            chk("pre_rst_rid", s_if.rid, 10'h30);
            tick();
        end
        arstn = 1'b0;
        set_m(1'b1, 10'h44, 64'hABCD, 1'b1);
        @(negedge clk);
        chk("rst_mid_svalid", s_if.rvalid, 1'b1);
        chk("rst_mid_rid", s_if.rid, 10'h44);
        chk("rst_mid_rdata", s_if.rdata, 64'hABCD);
        chk("rst_mid_mready", m_if.rready, 1'b1);
        tick();
        arstn = 1'b1;
        set_m(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_svalid", s_if.rvalid, 1'b0);
            chk("post_rst_mready", m_if.rready, 1'b1);
            tick();
        end

        // Maximum length drop, then len=0 shows the counter restarted at 0
        push(10'h3FF, 8'd255);
        bubble();
        burst(10'h3FF, 255);
        @(negedge clk);
        chk("max_done_mready", m_if.rready, 1'b1);
        tick();
        push(10'h01, 8'd0);
        bubble();
        burst(10'h01, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
